// File: rtl/tanimoto_cnt_accum.sv
// tanimoto_cnt_accum: pipelined two-operand popcount accumulator.
// Counts |A&B| and |A|B| per input word, accumulates both over a multi-word
// vector, and queues finished vector results in a small FWFT FIFO. Input
// backpressure is credit based, so a finished vector always has a FIFO slot.
module tanimoto_cnt_accum #(
  parameter int VECTOR_WIDTH   = 160,
  parameter int GRANULE_WIDTH  = 6,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VECTOR_WIDTH-1:0] i_VecA,
  input  logic [VECTOR_WIDTH-1:0] i_VecB,
  input  logic                    i_Valid,
  input  logic                    i_LastWordOfVector,
  output logic                    o_Ready,
  output logic [OUTPUT_WIDTH-1:0] o_CntAnd,
  output logic [OUTPUT_WIDTH-1:0] o_CntOr,
  output logic                    o_Sat,
  output logic                    o_Valid,
  input  logic                    i_Ready
);

  // The last granule may be narrower; the operand words are zero-padded up to
  // a whole number of granules so every granule is counted the same way.
  localparam int NumGran  = (VECTOR_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
  localparam int PadWidth = NumGran * GRANULE_WIDTH;
  localparam int GranCntW = $clog2(GRANULE_WIDTH + 1);
  localparam int WordCntW = $clog2(VECTOR_WIDTH + 1);
  localparam int SumW     = ((OUTPUT_WIDTH > WordCntW) ? OUTPUT_WIDTH : WordCntW) + 1;
  localparam int PtrW     = $clog2(OUT_FIFO_DEPTH);
  localparam int CntW     = $clog2(OUT_FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Input acceptance
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = i_Valid & o_Ready;

  // ---------------------------------------------------------------------------
  // Stage 1: per-granule popcounts
  // ---------------------------------------------------------------------------
  logic [PadWidth-1:0]                   andPad;
  logic [PadWidth-1:0]                   orPad;
  logic [NumGran-1:0][GranCntW-1:0]      s1And_d;
  logic [NumGran-1:0][GranCntW-1:0]      s1Or_d;
  logic [NumGran-1:0][GranCntW-1:0]      s1And_q;
  logic [NumGran-1:0][GranCntW-1:0]      s1Or_q;
  logic                                  s1Valid_q;
  logic                                  s1Last_q;

  // Count the set bits of A&B and A|B inside each granule of the input word.
  always_comb begin
    andPad                    = '0;
    orPad                     = '0;
    andPad[VECTOR_WIDTH-1:0]  = i_VecA & i_VecB;
    orPad[VECTOR_WIDTH-1:0]   = i_VecA | i_VecB;
    for (int g = 0; g < NumGran; g++) begin
      s1And_d[g] = '0;
      s1Or_d[g]  = '0;
      for (int b = 0; b < GRANULE_WIDTH; b++) begin
        s1And_d[g] = s1And_d[g] + GranCntW'(andPad[g*GRANULE_WIDTH + b]);
        s1Or_d[g]  = s1Or_d[g]  + GranCntW'(orPad[g*GRANULE_WIDTH + b]);
      end
    end
  end

  // Register granule counts for accepted words; tags follow every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1And_q   <= '0;
      s1Or_q    <= '0;
    end else begin
      s1Valid_q <= accept;
      s1Last_q  <= accept & i_LastWordOfVector;
      if (accept) begin
        s1And_q <= s1And_d;
        s1Or_q  <= s1Or_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: word totals
  // ---------------------------------------------------------------------------
  logic [WordCntW-1:0] s2And_d;
  logic [WordCntW-1:0] s2Or_d;
  logic [WordCntW-1:0] s2And_q;
  logic [WordCntW-1:0] s2Or_q;
  logic                s2Valid_q;
  logic                s2Last_q;

  // Reduce the granule counts to one total per operand combination.
  always_comb begin
    s2And_d = '0;
    s2Or_d  = '0;
    for (int g = 0; g < NumGran; g++) begin
      s2And_d = s2And_d + WordCntW'(s1And_q[g]);
      s2Or_d  = s2Or_d  + WordCntW'(s1Or_q[g]);
    end
  end

  // Register the word totals together with their tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      s2And_q   <= '0;
      s2Or_q    <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      s2Last_q  <= s1Last_q;
      if (s1Valid_q) begin
        s2And_q <= s2And_d;
        s2Or_q  <= s2Or_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: saturating accumulation
  // ---------------------------------------------------------------------------
  logic [OUTPUT_WIDTH-1:0] accAnd_q;
  logic [OUTPUT_WIDTH-1:0] accOr_q;
  logic                    sat_q;
  logic [OUTPUT_WIDTH-1:0] accAnd_d;
  logic [OUTPUT_WIDTH-1:0] accOr_d;
  logic                    sat_d;
  logic [SumW-1:0]         sumAnd;
  logic [SumW-1:0]         sumOr;
  logic                    ovfAnd;
  logic                    ovfOr;
  logic [OUTPUT_WIDTH-1:0] clampAnd;
  logic [OUTPUT_WIDTH-1:0] clampOr;
  logic                    satNew;
  logic                    push;

  // Add the word totals to the running sums, clamp on overflow, and either
  // keep accumulating or hand the finished vector to the FIFO.
  always_comb begin
    sumAnd   = SumW'(accAnd_q) + SumW'(s2And_q);
    sumOr    = SumW'(accOr_q)  + SumW'(s2Or_q);
    ovfAnd   = |sumAnd[SumW-1:OUTPUT_WIDTH];
    ovfOr    = |sumOr[SumW-1:OUTPUT_WIDTH];
    clampAnd = ovfAnd ? '1 : sumAnd[OUTPUT_WIDTH-1:0];
    clampOr  = ovfOr  ? '1 : sumOr[OUTPUT_WIDTH-1:0];
    satNew   = sat_q | ovfAnd | ovfOr;
    push     = s2Valid_q & s2Last_q;
    accAnd_d = accAnd_q;
    accOr_d  = accOr_q;
    sat_d    = sat_q;
    if (s2Valid_q) begin
      if (s2Last_q) begin
        accAnd_d = '0;
        accOr_d  = '0;
        sat_d    = 1'b0;
      end else begin
        accAnd_d = clampAnd;
        accOr_d  = clampOr;
        sat_d    = satNew;
      end
    end
  end

  // Accumulator and sticky saturation state.
  always_ff @(posedge clk) begin
    if (rst) begin
      accAnd_q <= '0;
      accOr_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      accAnd_q <= accAnd_d;
      accOr_q  <= accOr_d;
      sat_q    <= sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [OUTPUT_WIDTH-1:0] memAnd_q [OUT_FIFO_DEPTH];
  logic [OUTPUT_WIDTH-1:0] memOr_q  [OUT_FIFO_DEPTH];
  logic                    memSat_q [OUT_FIFO_DEPTH];
  logic [PtrW-1:0]         wrPtr_q;
  logic [PtrW-1:0]         rdPtr_q;
  logic [CntW-1:0]         count_q;
  logic [PtrW-1:0]         wrPtr_d;
  logic [PtrW-1:0]         rdPtr_d;
  logic [CntW-1:0]         count_d;
  logic                    pop;

  // The head is only presented outside reset; an empty FIFO reads as zero.
  assign o_Valid  = !rst && (count_q != '0);
  assign pop      = o_Valid & i_Ready;
  assign o_CntAnd = o_Valid ? memAnd_q[rdPtr_q] : '0;
  assign o_CntOr  = o_Valid ? memOr_q[rdPtr_q]  : '0;
  assign o_Sat    = o_Valid ? memSat_q[rdPtr_q] : 1'b0;

  // Pointer and occupancy bookkeeping; the depth need not be a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == PtrW'(OUT_FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PtrW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PtrW'(OUT_FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      memAnd_q[wrPtr_q] <= clampAnd;
      memOr_q[wrPtr_q]  <= clampOr;
      memSat_q[wrPtr_q] <= satNew;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit-based input backpressure
  // ---------------------------------------------------------------------------
  // Every vector end already in S1/S2 has a reserved FIFO slot, so a new word
  // is only taken while reserved plus occupied slots leave room for one more.
  logic [CntW:0] inFlight;

  assign inFlight = (CntW+1)'(count_q)
                  + (CntW+1)'(s1Valid_q & s1Last_q)
                  + (CntW+1)'(s2Valid_q & s2Last_q);
  assign o_Ready  = !rst && (inFlight < (CntW+1)'(OUT_FIFO_DEPTH));

endmodule

// File: tb/tb_tanimoto_cnt_accum.sv
// tb_tanimoto_cnt_accum: directed bench with a result scoreboard.
// Instance 0 uses the default parameters; instance 1 uses an 8-bit output
// width and a 2-entry FIFO to reach saturation and credit backpressure.
module tb_tanimoto_cnt_accum;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] o;
    logic        s;
  } res_t;

  logic         clk;
  logic         rst;
  logic [159:0] vecA [2];
  logic [159:0] vecB [2];
  logic         valid [2];
  logic         last [2];
  logic         rdy [2];
  logic         outValid [2];
  logic         outSat [2];
  logic         consReady [2];
  logic [15:0]  cntAnd0;
  logic [15:0]  cntOr0;
  logic [7:0]   cntAnd1;
  logic [7:0]   cntOr1;
  logic [15:0]  cntAndW [2];
  logic [15:0]  cntOrW [2];

  res_t expQ0 [$];
  res_t expQ1 [$];

  int total = 0;
  int bad   = 0;
  int st;
  int stallSum;
  logic [159:0] ra;
  logic [159:0] rb;
  logic [159:0] allOnes;

  assign cntAndW[0] = cntAnd0;
  assign cntOrW[0]  = cntOr0;
  assign cntAndW[1] = {8'd0, cntAnd1};
  assign cntOrW[1]  = {8'd0, cntOr1};

  tanimoto_cnt_accum u0 (
    .clk(clk), .rst(rst),
    .i_VecA(vecA[0]), .i_VecB(vecB[0]),
    .i_Valid(valid[0]), .i_LastWordOfVector(last[0]),
    .o_Ready(rdy[0]),
    .o_CntAnd(cntAnd0), .o_CntOr(cntOr0), .o_Sat(outSat[0]),
    .o_Valid(outValid[0]), .i_Ready(consReady[0])
  );

  tanimoto_cnt_accum #(.OUTPUT_WIDTH(8), .OUT_FIFO_DEPTH(2)) u1 (
    .clk(clk), .rst(rst),
    .i_VecA(vecA[1]), .i_VecB(vecB[1]),
    .i_Valid(valid[1]), .i_LastWordOfVector(last[1]),
    .o_Ready(rdy[1]),
    .o_CntAnd(cntAnd1), .o_CntOr(cntOr1), .o_Sat(outSat[1]),
    .o_Valid(outValid[1]), .i_Ready(consReady[1])
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qSize(input int s);
    return (s == 0) ? expQ0.size() : expQ1.size();
  endfunction

  function automatic res_t popExp(input int s);
    if (s == 0) return expQ0.pop_front();
    return expQ1.pop_front();
  endfunction

  task automatic pushExp(input int s, input int a, input int o, input logic sat);
    res_t e;
    e.a = 16'(a);
    e.o = 16'(o);
    e.s = sat;
    if (s == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
  endtask

  // Offer one word and hold it until accepted; called and returns at posedge+1.
  task automatic applyStimulus(input int sel, input logic [159:0] a, input logic [159:0] b,
                               input logic lst, output int stalls);
    logic took;
    stalls     = 0;
    vecA[sel]  = a;
    vecB[sel]  = b;
    last[sel]  = lst;
    valid[sel] = 1'b1;
    forever begin
      @(negedge clk);
      took = rdy[sel];
      @(posedge clk);
      #1;
      if (took) break;
      stalls++;
      if (stalls > 200) begin
        checkOutput($sformatf("accept_timeout%0d", sel), 32'(stalls), 32'd0);
        break;
      end
    end
    valid[sel] = 1'b0;
    last[sel]  = 1'b0;
  endtask

  // Wait (bounded) until every expected result of an instance was seen.
  task automatic drainWait(input int sel);
    int n = 0;
    while (qSize(sel) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checkOutput($sformatf("drain%0d", sel), 32'(qSize(sel)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the head whenever a pop is about to happen.
  always @(negedge clk) begin
    res_t e;
    for (int s = 0; s < 2; s++) begin
      if (outValid[s] && consReady[s]) begin
        if (qSize(s) == 0) begin
          checkOutput($sformatf("spurious_result%0d", s), 32'(outValid[s]), 32'd0);
        end else begin
          e = popExp(s);
          checkOutput($sformatf("res_and%0d", s), 32'(cntAndW[s]), 32'(e.a));
          checkOutput($sformatf("res_or%0d", s),  32'(cntOrW[s]),  32'(e.o));
          checkOutput($sformatf("res_sat%0d", s), 32'(outSat[s]),  32'(e.s));
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    allOnes = '1;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      vecA[s] = '0; vecB[s] = '0; valid[s] = 1'b0; last[s] = 1'b0; consReady[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(outValid[0]), 32'd0);
    checkOutput("rst_ready", 32'(rdy[0]), 32'd0);
    checkOutput("rst_and", 32'(cntAnd0), 32'd0);
    checkOutput("rst_sat", 32'(outSat[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;

    // Single word, latency of two edges to o_Valid.
    $display("[TB] single word");
    pushExp(0, 0, 160, 1'b0);
    applyStimulus(0, allOnes, 160'd0, 1'b1, st);
    @(negedge clk); checkOutput("lat_e0", 32'(outValid[0]), 32'd0);
    @(negedge clk); checkOutput("lat_e1", 32'(outValid[0]), 32'd0);
    @(negedge clk); checkOutput("lat_e2", 32'(outValid[0]), 32'd1);
    checkOutput("single_head_or", 32'(cntOr0), 32'd160);
    @(negedge clk); checkOutput("stall_hold_or", 32'(cntOr0), 32'd160);
    @(posedge clk); #1;
    consReady[0] = 1'b1;
    drainWait(0);

    // Two-word vector with a bubble between the words.
    $display("[TB] two words with bubble");
    pushExp(0, 160, 240, 1'b0);
    applyStimulus(0, {40{4'h1}}, {40{4'h3}}, 1'b0, st);
    @(posedge clk); #1;
    applyStimulus(0, {40{4'hF}}, {40{4'h7}}, 1'b1, st);
    drainWait(0);

    // Full-rate one-word vectors with the consumer always ready.
    $display("[TB] streaming");
    stallSum = 0;
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom};
      pushExp(0, $countones(ra & rb), $countones(ra | rb), 1'b0);
      applyStimulus(0, ra, rb, 1'b1, st);
      stallSum += st;
    end
    checkOutput("stream_no_stall", 32'(stallSum), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stream_one_per_cycle", 32'(expQ0.size()), 32'd0);
    drainWait(0);

    // Saturation at 8 bits, then a fresh vector with sat cleared.
    $display("[TB] saturation");
    consReady[1] = 1'b1;
    pushExp(1, 255, 255, 1'b1);
    applyStimulus(1, allOnes, allOnes, 1'b0, st);
    applyStimulus(1, allOnes, allOnes, 1'b1, st);
    pushExp(1, 40, 40, 1'b0);
    applyStimulus(1, {40{4'h1}}, {40{4'h1}}, 1'b1, st);
    drainWait(1);

    // Credit backpressure with a 2-entry FIFO and a stalled consumer.
    $display("[TB] backpressure");
    consReady[1] = 1'b0;
    pushExp(1, 1, 1, 1'b0);
    applyStimulus(1, 160'd1, 160'd1, 1'b1, st);
    pushExp(1, 1, 1, 1'b0);
    applyStimulus(1, 160'd2, 160'd2, 1'b1, st);
    checkOutput("bp_second_no_stall", 32'(st), 32'd0);
    vecA[1] = 160'd3; vecB[1] = 160'd3; last[1] = 1'b1; valid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_ready_low%0d", i), 32'(rdy[1]), 32'd0);
    end
    checkOutput("bp_head_valid", 32'(outValid[1]), 32'd1);
    checkOutput("bp_head_and", 32'(cntAnd1), 32'd1);
    @(posedge clk); #1;
    pushExp(1, 2, 2, 1'b0);
    consReady[1] = 1'b1;
    applyStimulus(1, 160'd3, 160'd3, 1'b1, st);
    pushExp(1, 1, 1, 1'b0);
    applyStimulus(1, 160'd4, 160'd4, 1'b1, st);
    drainWait(1);

    // Reset mid-vector with an undelivered result in the FIFO.
    $display("[TB] reset mid-vector");
    consReady[0] = 1'b0;
    applyStimulus(0, {40{4'h1}}, {40{4'h1}}, 1'b1, st);
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_valid", 32'(outValid[0]), 32'd1);
    @(posedge clk); #1;
    applyStimulus(0, allOnes, allOnes, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_rst_valid", 32'(outValid[0]), 32'd0);
    checkOutput("in_rst_and", 32'(cntAnd0), 32'd0);
    checkOutput("in_rst_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_valid", 32'(outValid[0]), 32'd0);
    checkOutput("after_rst_or", 32'(cntOr0), 32'd0);
    checkOutput("after_rst_sat", 32'(outSat[0]), 32'd0);
    checkOutput("after_rst_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    consReady[0] = 1'b1;
    pushExp(0, 160, 160, 1'b0);
    applyStimulus(0, allOnes, allOnes, 1'b1, st);
    drainWait(0);
    repeat (4) @(negedge clk);
    checkOutput("final_idle0", 32'(outValid[0]), 32'd0);
    checkOutput("final_idle1", 32'(outValid[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
